// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready handshake, flush, and control masking when the stage is empty.
// Optional skid entry (define EXMEM_SKID_EN) makes in_ready registered instead of combinational from out_ready.
module exmem_pipe_reg #(
  parameter int DATA_WIDTH      = 48,
  parameter int REG_ADDR_WIDTH  = 3,
  parameter int MEM_CTRL_WIDTH  = 3,
  parameter int WB_CTRL_WIDTH   = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [MEM_CTRL_WIDTH-1:0]  mem_ctrl_in,
  input  logic [WB_CTRL_WIDTH-1:0]   wb_ctrl_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [MEM_CTRL_WIDTH-1:0]  mem_ctrl_out,
  output logic [WB_CTRL_WIDTH-1:0]   wb_ctrl_out,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  logic in_xfer;
  logic main_free;

  assign in_xfer   = in_valid && in_ready && !flush;
  assign main_free = !out_valid || out_ready;

`ifdef EXMEM_SKID_EN
  logic                      skid_valid;
  logic [DATA_WIDTH-1:0]     skid_data;
  logic [REG_ADDR_WIDTH-1:0] skid_reg_addr;
  logic [MEM_CTRL_WIDTH-1:0] skid_mem_ctrl;
  logic [WB_CTRL_WIDTH-1:0]  skid_wb_ctrl;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      reg_addr_out  <= '0;
      mem_ctrl_out  <= '0;
      wb_ctrl_out   <= '0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_reg_addr <= '0;
      skid_mem_ctrl <= '0;
      skid_wb_ctrl  <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      mem_ctrl_out <= '0;
      wb_ctrl_out  <= '0;
      skid_valid   <= 1'b0;
    end else if (main_free) begin
      // The skid entry is older than anything on the input, so it refills main first.
      if (skid_valid) begin
        out_valid    <= 1'b1;
        data_out     <= skid_data;
        reg_addr_out <= skid_reg_addr;
        mem_ctrl_out <= skid_mem_ctrl;
        wb_ctrl_out  <= skid_wb_ctrl;
        skid_valid   <= 1'b0;
      end else if (in_xfer) begin
        out_valid    <= 1'b1;
        data_out     <= data_in;
        reg_addr_out <= reg_addr_in;
        mem_ctrl_out <= mem_ctrl_in;
        wb_ctrl_out  <= wb_ctrl_in;
      end else begin
        out_valid    <= 1'b0;
        mem_ctrl_out <= '0;
        wb_ctrl_out  <= '0;
      end
    end else if (in_xfer) begin
      skid_valid    <= 1'b1;
      skid_data     <= data_in;
      skid_reg_addr <= reg_addr_in;
      skid_mem_ctrl <= mem_ctrl_in;
      skid_wb_ctrl  <= wb_ctrl_in;
    end
  end
`else
  assign in_ready = main_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      data_out     <= '0;
      reg_addr_out <= '0;
      mem_ctrl_out <= '0;
      wb_ctrl_out  <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      mem_ctrl_out <= '0;
      wb_ctrl_out  <= '0;
    end else if (in_xfer) begin
      out_valid    <= 1'b1;
      data_out     <= data_in;
      reg_addr_out <= reg_addr_in;
      mem_ctrl_out <= mem_ctrl_in;
      wb_ctrl_out  <= wb_ctrl_in;
    end else if (out_valid && out_ready) begin
      // Data and address go stale; only the control bits must be squashed.
      out_valid    <= 1'b0;
      mem_ctrl_out <= '0;
      wb_ctrl_out  <= '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Bench for exmem_pipe_reg: directed scenarios plus random traffic, checked against an in-order item queue model.
module tb_exmem_pipe_reg;
  localparam int DW   = 48;
  localparam int AW   = 3;
  localparam int MW   = 3;
  localparam int WW   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [WW-1:0] w;
  } item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [MW-1:0] mem_ctrl_in = '0;
  logic [WW-1:0] wb_ctrl_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] data_out;
  logic [AW-1:0] reg_addr_out;
  logic [MW-1:0] mem_ctrl_out;
  logic [WW-1:0] wb_ctrl_out;
  logic [CW-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  item_t exp_q[$];
  int    mcnt = 0;
  bit    m_vld;
  bit    m_rdy;
  item_t m_it;

  exmem_pipe_reg #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .MEM_CTRL_WIDTH(MW),
    .WB_CTRL_WIDTH(WW), .STALL_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .data_in(data_in), .reg_addr_in(reg_addr_in), .mem_ctrl_in(mem_ctrl_in),
    .wb_ctrl_in(wb_ctrl_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .reg_addr_out(reg_addr_out), .mem_ctrl_out(mem_ctrl_out),
    .wb_ctrl_out(wb_ctrl_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
  endtask

  // Scoreboard: the queue holds every accepted, not-yet-consumed instruction in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      m_vld = (exp_q.size() > 0);
`ifdef EXMEM_SKID_EN
      m_rdy = (exp_q.size() < 2);
`else
      m_rdy = !m_vld || out_ready;
`endif
      chk("out_valid", out_valid, m_vld);
      chk("in_ready", in_ready, m_rdy);
      chk("stall_cnt", stall_cnt, mcnt);
      if (m_vld) begin
        chk("data_out", data_out, exp_q[0].d);
        chk("reg_addr_out", reg_addr_out, exp_q[0].a);
        chk("mem_ctrl_out", mem_ctrl_out, exp_q[0].m);
        chk("wb_ctrl_out", wb_ctrl_out, exp_q[0].w);
        if (out_ready) void'(exp_q.pop_front());
        else if (mcnt < CMAX) mcnt++;
      end else begin
        chk("mem_ctrl_masked", mem_ctrl_out, 0);
        chk("wb_ctrl_masked", wb_ctrl_out, 0);
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && m_rdy) begin
        m_it.d = data_in;
        m_it.a = reg_addr_in;
        m_it.m = mem_ctrl_in;
        m_it.w = wb_ctrl_in;
        exp_q.push_back(m_it);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in(input bit v);
    logic [63:0] r;
    r = {$urandom, $urandom};
    in_valid    = v;
    data_in     = r[DW-1:0];
    reg_addr_in = AW'($urandom);
    mem_ctrl_in = MW'($urandom);
    wb_ctrl_in  = WW'($urandom);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_reg_addr_out", reg_addr_out, 0);
    chk("rst_mem_ctrl_out", mem_ctrl_out, 0);
    chk("rst_wb_ctrl_out", wb_ctrl_out, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #3;
    chk_reset_outputs();
    #4 rst = 1'b0;
    step();

    // Streaming at full rate
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    data_in     = 48'h0000_0000_00A5;
    reg_addr_in = 3'd5;
    mem_ctrl_in = 3'b010;
    wb_ctrl_in  = 2'b11;
    step();
    chk("stream_valid", out_valid, 1);
    chk("stream_data", data_out, 48'h0000_0000_00A5);
    chk("stream_addr", reg_addr_out, 5);
    chk("stream_mem", mem_ctrl_out, 3'b010);
    chk("stream_wb", wb_ctrl_out, 2'b11);
    for (int i = 0; i < 3; i++) begin
      rnd_in(1'b1);
      step();
    end

    // Stall for four cycles while EX keeps offering
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd_in(1'b1);
      step();
    end
    chk("stall_cnt_4", stall_cnt, 4);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Bubble masking with garbage control on the input
    in_valid    = 1'b0;
    mem_ctrl_in = 3'b111;
    wb_ctrl_in  = 2'b11;
    step();
    chk("bubble_valid", out_valid, 0);
    chk("bubble_mem", mem_ctrl_out, 0);
    chk("bubble_wb", wb_ctrl_out, 0);

    // Flush a stalled entry together with a new input
    out_ready = 1'b0;
    rnd_in(1'b1);
    step();
    rnd_in(1'b1);
    step();
    flush = 1'b1;
    rnd_in(1'b1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Reset mid-transfer with a stalled valid entry
    out_ready = 1'b0;
    rnd_in(1'b1);
    step();
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", stall_cnt, CMAX);
    step();
    chk("stall_sat_hold", stall_cnt, CMAX);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rnd_in($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/exmem_pipe_reg.md
# exmem_pipe_reg

Parametrised EX/MEM pipeline register with a valid/ready handshake, flush, and bubble masking. It sits between the execute stage (ALU result, destination register, MEM/WB control) and the memory stage. It replaces the free-running EX/MEM latch with a stallable, flushable stage whose control outputs are forced to zero whenever the stage holds no valid instruction. An optional skid buffer breaks the combinational ready path.

## Interface
Parameters:
- DATA_WIDTH, 48, width of the ALU result/store data bundle
- REG_ADDR_WIDTH, 3, destination register address width
- MEM_CTRL_WIDTH, 3, memory-stage control width
- WB_CTRL_WIDTH, 2, write-back control width
- STALL_CNT_WIDTH, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  EX stage presents a valid instruction
- in_ready  out  1  stage accepts input this cycle
- flush  in  1  kill stored and incoming instructions (branch mispredict, exception)
- data_in  in  DATA_WIDTH  ALU result / store data
- reg_addr_in  in  REG_ADDR_WIDTH  destination register
- mem_ctrl_in  in  MEM_CTRL_WIDTH  memory control
- wb_ctrl_in  in  WB_CTRL_WIDTH  write-back control
- out_valid  out  1  stage holds a valid instruction
- out_ready  in  1  MEM stage consumes the output this cycle
- data_out  out  DATA_WIDTH  registered data
- reg_addr_out  out  REG_ADDR_WIDTH  registered destination register
- mem_ctrl_out  out  MEM_CTRL_WIDTH  registered memory control; 0 when out_valid=0
- wb_ctrl_out  out  WB_CTRL_WIDTH  registered write-back control; 0 when out_valid=0
- stall_cnt  out  STALL_CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Input transfer: in_valid && in_ready && !flush. Output transfer: out_valid && out_ready.
- Main register load: on an input transfer when the main register is empty or is being drained in the same cycle. Data, address and control are captured together, and out_valid is set.
- Drain without refill: out_valid clears. data_out and reg_addr_out keep their stale values. mem_ctrl_out and wb_ctrl_out are masked to 0.
- Hold: out_valid=1 and out_ready=0 keeps all fields unchanged.
- Flush: on the next edge, out_valid=0 and any skid entry is cleared. A same-cycle input is discarded. Flush takes priority over every other event.
- Stall counter:
  - Increments each cycle out_valid=1 and out_ready=0.
  - Saturates at all-ones.
  - Clears to 0 on rst only.

## Timing
- Reset (asynchronous, immediate):
  - out_valid=0; data_out, reg_addr_out, mem_ctrl_out, wb_ctrl_out and stall_cnt are 0.
  - in_ready=1 while rst is asserted and in the first cycle after release.
- Latency: one cycle from an input transfer to out_valid=1 with the captured fields.
- Throughput: one instruction per cycle when out_ready is held at 1.
- Without skid: in_ready = !out_valid || out_ready (combinational from out_ready).
- Back-to-back: an input transfer and an output transfer in the same cycle replace the contents, and out_valid stays 1.
- Flush combined with out_ready=1 in the same cycle: the output transfer still counts downstream. The stage is empty next cycle.
- Reset released mid-stream: the input sampled on the first edge after release is accepted normally.

## Configuration
- EXMEM_SKID_EN defined:
  - Adds one skid entry. in_ready becomes registered: in_ready = !skid_valid.
  - An input accepted while the main register is full and stalled goes to the skid entry.
  - When the main register drains, the skid entry moves to main on the same edge.
  - Ordering is preserved; there is no combinational path from out_ready to in_ready.
- EXMEM_SKID_EN undefined: single register with the combinational in_ready described above; no skid state.

## Test plan
- Reset: assert rst mid-transfer -> outputs immediately 0, out_valid=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1; in_valid=1 with data_in=0x0000_0000_00A5, reg_addr_in=5, mem_ctrl_in=3'b010, wb_ctrl_in=2'b11 -> same values at the outputs one cycle later; next items follow at one per cycle.
- Stall: out_ready=0 for 4 cycles with a valid entry -> outputs held and stall_cnt=4.
  - Without skid: in_ready=0 throughout.
  - With skid: exactly one extra item accepted, then in_ready=0; on release, both items emerge in order on consecutive cycles.
- Bubble masking: in_valid=0 with mem_ctrl_in=3'b111 and wb_ctrl_in=2'b11 -> out_valid=0, mem_ctrl_out=0, wb_ctrl_out=0.
- Flush: flush=1 together with in_valid=1 while holding a valid stalled entry -> next cycle out_valid=0 and the skid entry is empty; the incoming item never appears.
- Saturation: STALL_CNT_WIDTH=4 with out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
